// File: rtl/reg_write_arbiter_if.sv
// Request/grant bus between the requesting units and the write arbiter, plus the
// register-side write port driven by the arbiter.
interface reg_write_arbiter_if #(
  parameter int unsigned DataW = 8,
  parameter int unsigned NReq  = 4
);
  logic [NReq-1:0]       req;
  logic [NReq*DataW-1:0] req_data;
  logic [NReq-1:0]       gnt;
  logic [NReq-1:0]       ack;
  logic                  reg_wr;
  logic [DataW-1:0]      reg_in;
  logic                  busy;

  modport master (
    output req, req_data,
    input  gnt, ack, reg_wr, reg_in, busy
  );

  modport slave (
    input  req, req_data,
    output gnt, ack, reg_wr, reg_in, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a single shared register: grants one requester,
// captures its data, pulses the register write for one cycle, then acknowledges.
module reg_write_arbiter #(
  parameter int unsigned DataW = 8,
  parameter int unsigned NReq  = 4
) (
  input logic               clk,
  input logic               rst_n,
  reg_write_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (NReq > 1) ? $clog2(NReq) : 1;

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [PtrW-1:0]   win_q, win_d;
  logic [NReq-1:0]   gnt_q, gnt_d;
  logic [NReq-1:0]   ack_q, ack_d;
  logic              reg_wr_q, reg_wr_d;
  logic [DataW-1:0]  reg_in_q, reg_in_d;
  logic              busy_q, busy_d;

  logic              rr_valid;
  logic [PtrW-1:0]   rr_win;
  logic [PtrW-1:0]   rr_cand;

  // First set request after the last winner, wrapping modulo NReq.
  always_comb begin
    rr_valid = 1'b0;
    rr_win   = ptr_q;
    rr_cand  = ptr_q;
    for (int unsigned i = 1; i <= NReq; i++) begin
      rr_cand = PtrW'((32'(ptr_q) + i) % NReq);
      if (!rr_valid && bus.req[rr_cand]) begin
        rr_valid = 1'b1;
        rr_win   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    reg_wr_d = 1'b0;
    reg_in_d = reg_in_q;
    busy_d   = busy_q;
    unique case (state_q)
      StIdle: begin
        if (rr_valid) begin
          state_d        = StWrite;
          win_d          = rr_win;
          gnt_d          = '0;
          gnt_d[rr_win]  = 1'b1;
          reg_in_d       = bus.req_data[32'(rr_win) * DataW +: DataW];
          reg_wr_d       = 1'b1;
          busy_d         = 1'b1;
        end
      end
      StWrite: begin
        state_d = StDone;
        ack_d   = gnt_q;
        ptr_d   = win_q;
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Pointer resets to the last index so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= PtrW'(NReq - 1);
      win_q    <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      reg_wr_q <= 1'b0;
      reg_in_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      reg_wr_q <= reg_wr_d;
      reg_in_q <= reg_in_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.reg_wr = reg_wr_q;
  assign bus.reg_in = reg_in_q;
  assign bus.busy   = busy_q;

endmodule
